// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths and forward-source encoding for the MIPS operand path
package mips_pkg;

    localparam int WIDTH_DEF      = 32;
    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/operand_fwd_sel.sv
// rtl/operand_fwd_sel.sv - combinational RAW-hazard forward select for one source register
module operand_fwd_sel
    import mips_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] i_reg,
    input  logic [WIDTH-1:0]      i_reg_data,
    input  logic                  i_exmem_wr,
    input  logic [REG_ADDR_W-1:0] i_exmem_rd,
    input  logic [WIDTH-1:0]      i_exmem_result,
    input  logic                  i_memwb_wr,
    input  logic [REG_ADDR_W-1:0] i_memwb_rd,
    input  logic [WIDTH-1:0]      i_memwb_result,
    output logic [WIDTH-1:0]      o_value,
    output fwd_sel_t              o_sel
);

    logic w_nonzero;

    assign w_nonzero = (i_reg != '0);

    // Younger producer (EX/MEM) wins over MEM/WB; $zero is hard-wired and never forwarded
    always_comb begin
        o_value = i_reg_data;
        o_sel   = FWD_NONE;
        if (i_exmem_wr && (i_exmem_rd == i_reg) && w_nonzero) begin
            o_value = i_exmem_result;
            o_sel   = FWD_EXMEM;
        end else if (i_memwb_wr && (i_memwb_rd == i_reg) && w_nonzero) begin
            o_value = i_memwb_result;
            o_sel   = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - registered ID/EX operand stage with forwarding; FWD_COUNT_EN adds forward counters
module alu_operand_stage
    import mips_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
`ifdef FWD_COUNT_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      readData1,
    input  logic [WIDTH-1:0]      readData2,
    input  logic [WIDTH-1:0]      signExtend,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic                  aluSrc,
    input  logic                  exmemRegWrite,
    input  logic [REG_ADDR_W-1:0] exmemRd,
    input  logic [WIDTH-1:0]      exmemResult,
    input  logic                  memwbRegWrite,
    input  logic [REG_ADDR_W-1:0] memwbRd,
    input  logic [WIDTH-1:0]      memwbResult,
    output logic [WIDTH-1:0]      opA,
    output logic [WIDTH-1:0]      opB,
    output logic [WIDTH-1:0]      storeData,
    output logic                  out_valid,
    output fwd_sel_t              fwdA,
    output fwd_sel_t              fwdB
`ifdef FWD_COUNT_EN
    ,
    output logic [CNT_W-1:0]      fwdCountExmem,
    output logic [CNT_W-1:0]      fwdCountMemwb
`endif
);

    logic [WIDTH-1:0] w_val_a;
    logic [WIDTH-1:0] w_val_b;
    logic [WIDTH-1:0] w_op_b;
    fwd_sel_t         w_sel_a;
    fwd_sel_t         w_sel_b;
    logic             w_load;

    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_store_data;
    logic             r_valid;
    fwd_sel_t         r_fwd_a;
    fwd_sel_t         r_fwd_b;

    operand_fwd_sel #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
        .i_reg          (rs),
        .i_reg_data     (readData1),
        .i_exmem_wr     (exmemRegWrite),
        .i_exmem_rd     (exmemRd),
        .i_exmem_result (exmemResult),
        .i_memwb_wr     (memwbRegWrite),
        .i_memwb_rd     (memwbRd),
        .i_memwb_result (memwbResult),
        .o_value        (w_val_a),
        .o_sel          (w_sel_a)
    );

    operand_fwd_sel #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
        .i_reg          (rt),
        .i_reg_data     (readData2),
        .i_exmem_wr     (exmemRegWrite),
        .i_exmem_rd     (exmemRd),
        .i_exmem_result (exmemResult),
        .i_memwb_wr     (memwbRegWrite),
        .i_memwb_rd     (memwbRd),
        .i_memwb_result (memwbResult),
        .o_value        (w_val_b),
        .o_sel          (w_sel_b)
    );

    // The immediate replaces only opB; storeData and fwdB keep reporting the rt path
    assign w_op_b = aluSrc ? signExtend : w_val_b;
    assign w_load = !flush && !stall;

    // Pipeline register: reset beats flush, flush beats stall; data loads even for invalid slots
    always_ff @(posedge clock) begin
        if (reset) begin
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_store_data <= '0;
            r_valid      <= 1'b0;
            r_fwd_a      <= FWD_NONE;
            r_fwd_b      <= FWD_NONE;
        end else if (flush) begin
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_store_data <= '0;
            r_valid      <= 1'b0;
            r_fwd_a      <= FWD_NONE;
            r_fwd_b      <= FWD_NONE;
        end else if (!stall) begin
            r_op_a       <= w_val_a;
            r_op_b       <= w_op_b;
            r_store_data <= w_val_b;
            r_valid      <= in_valid;
            r_fwd_a      <= w_sel_a;
            r_fwd_b      <= w_sel_b;
        end
    end

    assign opA       = r_op_a;
    assign opB       = r_op_b;
    assign storeData = r_store_data;
    assign out_valid = r_valid;
    assign fwdA      = r_fwd_a;
    assign fwdB      = r_fwd_b;

`ifdef FWD_COUNT_EN
    logic             w_hit_exmem;
    logic             w_hit_memwb;
    logic [CNT_W-1:0] r_cnt_exmem;
    logic [CNT_W-1:0] r_cnt_memwb;

    // One count per instruction, no matter whether one or both operands used the source
    assign w_hit_exmem = in_valid && ((w_sel_a == FWD_EXMEM) || (w_sel_b == FWD_EXMEM));
    assign w_hit_memwb = in_valid && ((w_sel_a == FWD_MEMWB) || (w_sel_b == FWD_MEMWB));

    // Saturating event counters, advancing only on real loads and cleared only by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt_exmem <= '0;
            r_cnt_memwb <= '0;
        end else if (w_load) begin
            if (w_hit_exmem && (r_cnt_exmem != '1)) begin
                r_cnt_exmem <= r_cnt_exmem + 1'b1;
            end
            if (w_hit_memwb && (r_cnt_memwb != '1)) begin
                r_cnt_memwb <= r_cnt_memwb + 1'b1;
            end
        end
    end

    assign fwdCountExmem = r_cnt_exmem;
    assign fwdCountMemwb = r_cnt_memwb;
`else
    logic w_unused_load;
    assign w_unused_load = w_load;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - scoreboard bench for alu_operand_stage with directed vectors
module tb_alu_operand_stage;

    typedef struct {
        logic        reset, in_valid, stall, flush;
        logic [31:0] rd1, rd2, se;
        logic [4:0]  rs, rt;
        logic        alu_src;
        logic        exw;
        logic [4:0]  exrd;
        logic [31:0] exres;
        logic        mww;
        logic [4:0]  mwrd;
        logic [31:0] mwres;
    } stim_t;

    typedef struct {
        logic [31:0] opa, opb, sd;
        logic        v;
        logic [1:0]  fa, fb;
        logic        chk_cnt;
        logic [1:0]  cx, cm;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset, in_valid, stall, flush;
    logic [31:0] readData1, readData2, signExtend;
    logic [4:0]  rs, rt;
    logic        aluSrc;
    logic        exmemRegWrite;
    logic [4:0]  exmemRd;
    logic [31:0] exmemResult;
    logic        memwbRegWrite;
    logic [4:0]  memwbRd;
    logic [31:0] memwbResult;
    logic [31:0] opA, opB, storeData;
    logic        out_valid;
    mips_pkg::fwd_sel_t fwdA, fwdB;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

`ifdef FWD_COUNT_EN
    logic [1:0] fwdCountExmem, fwdCountMemwb;

    alu_operand_stage #(.WIDTH(32), .REG_ADDR_W(5), .CNT_W(2)) dut (
`else
    alu_operand_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
`endif
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .stall         (stall),
        .flush         (flush),
        .readData1     (readData1),
        .readData2     (readData2),
        .signExtend    (signExtend),
        .rs            (rs),
        .rt            (rt),
        .aluSrc        (aluSrc),
        .exmemRegWrite (exmemRegWrite),
        .exmemRd       (exmemRd),
        .exmemResult   (exmemResult),
        .memwbRegWrite (memwbRegWrite),
        .memwbRd       (memwbRd),
        .memwbResult   (memwbResult),
        .opA           (opA),
        .opB           (opB),
        .storeData     (storeData),
        .out_valid     (out_valid),
        .fwdA          (fwdA),
        .fwdB          (fwdB)
`ifdef FWD_COUNT_EN
        ,
        .fwdCountExmem (fwdCountExmem),
        .fwdCountMemwb (fwdCountMemwb)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{reset:1'b0, in_valid:1'b0, stall:1'b0, flush:1'b0, rd1:32'h0, rd2:32'h0,
              se:32'h0, rs:5'd0, rt:5'd0, alu_src:1'b0, exw:1'b0, exrd:5'd0, exres:32'h0,
              mww:1'b0, mwrd:5'd0, mwres:32'h0};
        return s;
    endfunction

    function automatic exp_t ex(input logic [31:0] opa, input logic [31:0] opb,
                                input logic [31:0] sd, input logic v,
                                input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e = '{opa:opa, opb:opb, sd:sd, v:v, fa:fa, fb:fb, chk_cnt:1'b0, cx:2'd0, cm:2'd0};
        return e;
    endfunction

    task automatic apply(input stim_t s, input exp_t e);
        @(negedge clock);
        reset         = s.reset;
        in_valid      = s.in_valid;
        stall         = s.stall;
        flush         = s.flush;
        readData1     = s.rd1;
        readData2     = s.rd2;
        signExtend    = s.se;
        rs            = s.rs;
        rt            = s.rt;
        aluSrc        = s.alu_src;
        exmemRegWrite = s.exw;
        exmemRd       = s.exrd;
        exmemResult   = s.exres;
        memwbRegWrite = s.mww;
        memwbRd       = s.mwrd;
        memwbResult   = s.mwres;
        sb.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle, one expectation per issued vector
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("opA",       opA,                 e.opa);
                chk("opB",       opB,                 e.opb);
                chk("storeData", storeData,           e.sd);
                chk("out_valid", {31'd0, out_valid},  {31'd0, e.v});
                chk("fwdA",      {30'd0, fwdA},       {30'd0, e.fa});
                chk("fwdB",      {30'd0, fwdB},       {30'd0, e.fb});
`ifdef FWD_COUNT_EN
                if (e.chk_cnt) begin
                    chk("fwdCountExmem", {30'd0, fwdCountExmem}, {30'd0, e.cx});
                    chk("fwdCountMemwb", {30'd0, fwdCountMemwb}, {30'd0, e.cm});
                end
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        exp_t  e0, e_hold;

        {reset, in_valid, stall, flush, aluSrc, exmemRegWrite, memwbRegWrite} = 7'b1000000;
        {readData1, readData2, signExtend, exmemResult, memwbResult} = '0;
        {rs, rt, exmemRd, memwbRd} = '0;
        e0 = ex(32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00);
        e0.chk_cnt = 1'b1;

        // Reset with random inputs on every other port
        for (int i = 0; i < 2; i++) begin
            s = '{reset:1'b1, in_valid:1'($urandom), stall:1'($urandom), flush:1'($urandom),
                  rd1:$urandom, rd2:$urandom, se:$urandom, rs:5'($urandom), rt:5'($urandom),
                  alu_src:1'($urandom), exw:1'b1, exrd:5'($urandom), exres:$urandom,
                  mww:1'b1, mwrd:5'($urandom), mwres:$urandom};
            apply(s, e0);
        end

        // rs hit in both stages: EX/MEM wins; rt=0 stays on the register file
        s = idle(); s.in_valid = 1; s.rs = 3; s.rd1 = 32'h5; s.rd2 = 32'h22;
        s.exw = 1; s.exrd = 3; s.exres = 32'hAA; s.mww = 1; s.mwrd = 3; s.mwres = 32'hBB;
        apply(s, ex(32'hAA, 32'h22, 32'h22, 1'b1, 2'b10, 2'b00));

        // Register 0 is never forwarded
        s = idle(); s.in_valid = 1; s.rt = 0; s.rd2 = 32'h7; s.rs = 0; s.rd1 = 32'h9;
        s.exw = 1; s.exrd = 0; s.exres = 32'hFF;
        apply(s, ex(32'h9, 32'h7, 32'h7, 1'b1, 2'b00, 2'b00));

        // Immediate on opB, rt from MEM/WB still drives storeData and fwdB; rs from EX/MEM
        s = idle(); s.in_valid = 1; s.alu_src = 1; s.se = 32'hFFFF_FFFC;
        s.rt = 4; s.rd2 = 32'h44; s.mww = 1; s.mwrd = 4; s.mwres = 32'h11;
        s.rs = 5; s.rd1 = 32'h1; s.exw = 1; s.exrd = 5; s.exres = 32'h55;
        apply(s, ex(32'h55, 32'hFFFF_FFFC, 32'h11, 1'b1, 2'b10, 2'b01));

        // rt priority, invalid slot still loads data
        s = idle(); s.rt = 6; s.rd2 = 32'h60; s.exw = 1; s.exrd = 6; s.exres = 32'h66;
        s.mww = 1; s.mwrd = 6; s.mwres = 32'h77; s.rs = 7; s.rd1 = 32'h70;
        apply(s, ex(32'h70, 32'h66, 32'h66, 1'b0, 2'b00, 2'b10));

        // rs from MEM/WB when EX/MEM has a matching rd but no write
        s = idle(); s.in_valid = 1; s.rs = 8; s.rd1 = 32'h80; s.mww = 1; s.mwrd = 8;
        s.mwres = 32'h88; s.exw = 0; s.exrd = 8; s.exres = 32'h99; s.rt = 9; s.rd2 = 32'h90;
        apply(s, ex(32'h88, 32'h90, 32'h90, 1'b1, 2'b01, 2'b00));

        // Load a valid op, then stall for three cycles with new inputs
        s = idle(); s.in_valid = 1; s.rs = 1; s.rd1 = 32'h100; s.rt = 2; s.rd2 = 32'h200;
        e_hold = ex(32'h100, 32'h200, 32'h200, 1'b1, 2'b00, 2'b00);
        apply(s, e_hold);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.stall = 1; s.in_valid = 1'(i); s.rs = 3; s.rd1 = 32'h333;
            s.exw = 1; s.exrd = 3; s.exres = 32'hC0DE + 32'(i); s.rt = 4; s.rd2 = 32'h444;
            apply(s, e_hold);
        end

        // Flush beats stall
        s = idle(); s.stall = 1; s.flush = 1; s.in_valid = 1; s.rs = 1; s.rd1 = 32'h123;
        apply(s, ex(32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00));

`ifdef FWD_COUNT_EN
        begin
            exp_t ec;
            s = idle(); s.reset = 1;
            apply(s, e0);

            // Invalid slot using EX/MEM does not count
            s = idle(); s.rs = 3; s.exw = 1; s.exrd = 3; s.exres = 32'hAA;
            ec = ex(32'hAA, 32'h0, 32'h0, 1'b0, 2'b10, 2'b00);
            ec.chk_cnt = 1; ec.cx = 0; ec.cm = 0;
            apply(s, ec);

            // Five valid EX/MEM cycles with both operands hitting: 1,2,3,3,3
            for (int i = 0; i < 5; i++) begin
                s = idle(); s.in_valid = 1; s.rs = 3; s.rt = 3; s.exw = 1; s.exrd = 3;
                s.exres = 32'hAA;
                ec = ex(32'hAA, 32'hAA, 32'hAA, 1'b1, 2'b10, 2'b10);
                ec.chk_cnt = 1; ec.cx = (i < 3) ? 2'(i + 1) : 2'd3; ec.cm = 0;
                apply(s, ec);
            end

            // One valid MEM/WB cycle, then a stalled one that must not count
            s = idle(); s.in_valid = 1; s.rs = 3; s.mww = 1; s.mwrd = 3; s.mwres = 32'hBB;
            ec = ex(32'hBB, 32'h0, 32'h0, 1'b1, 2'b01, 2'b00);
            ec.chk_cnt = 1; ec.cx = 3; ec.cm = 1;
            apply(s, ec);
            s.stall = 1;
            apply(s, ec);

            // Flush holds the counters
            s.stall = 0; s.flush = 1;
            ec = ex(32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00);
            ec.chk_cnt = 1; ec.cx = 3; ec.cm = 1;
            apply(s, ec);
        end
`endif

        s = idle();
        apply(s, ex(32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00));
        repeat (3) @(posedge clock);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
